// File: rtl/tagged_branch_predictor.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB plus saturating-counter BHT with
// bimodal or gshare indexing, speculative global history and a cap on unresolved hit predictions.
module tagged_branch_predictor #(
  parameter int PC_WIDTH    = 64,
  parameter int INDEX_BITS  = 10,
  parameter int TAG_BITS    = 8,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 8,
  parameter int GSHARE      = 0,
  parameter int MAX_PENDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               lookup_valid,
  input  logic [PC_WIDTH-1:0]                lookup_pc,
  output logic                               lookup_ready,
  output logic                               pred_valid,
  output logic                               pred_hit,
  output logic                               pred_taken,
  output logic [PC_WIDTH-1:0]                pred_pc,
  output logic [GHR_BITS-1:0]                pred_ghr,
  input  logic                               update_valid,
  input  logic [PC_WIDTH-1:0]                update_pc,
  input  logic                               update_taken,
  input  logic [PC_WIDTH-1:0]                update_target,
  input  logic [GHR_BITS-1:0]                update_ghr,
  input  logic                               update_mispredict,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
  output logic                               o_dbg_state
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);
  localparam logic [CTR_BITS-1:0]   CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]   CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0]   CTR_MIN     = '0;
  localparam logic [INDEX_BITS-1:0] IDX_LAST    = '1;
  localparam logic [PEND_W-1:0]     PEND_MAX    = PEND_W'(MAX_PENDING);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_sweep_idx;
  logic [GHR_BITS-1:0]   r_ghr;
  logic [PEND_W-1:0]     r_pending;
  logic                  r_pred_valid;
  logic                  r_pred_hit;
  logic                  r_pred_taken;
  logic [PC_WIDTH-1:0]   r_pred_pc;
  logic [GHR_BITS-1:0]   r_pred_ghr;

  logic                  r_btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0]   r_btb_tag    [ENTRIES];
  logic [PC_WIDTH-1:0]   r_btb_target [ENTRIES];
  logic [CTR_BITS-1:0]   r_bht        [ENTRIES];

  // Handshake: a lookup is taken on a rising edge where lookup_valid && lookup_ready; its
  // prediction appears on pred_* after that edge with pred_valid high for exactly one cycle.
  // Updates have no back-pressure and are only acted on once the table sweep has finished.
  logic                  w_lookup_ready;
  logic                  w_accept;
  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic [INDEX_BITS-1:0] w_lk_bht_idx;
  logic                  w_hit;
  logic                  w_taken;
  logic [PC_WIDTH-1:0]   w_pred_pc;

  logic                  w_upd;
  logic                  w_flush;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]   w_up_tag;
  logic [INDEX_BITS-1:0] w_up_bht_idx;
  logic [CTR_BITS-1:0]   w_up_ctr;
  logic [CTR_BITS-1:0]   w_ctr_next;

  logic                  w_inc;
  logic [PEND_W-1:0]     w_pending_next;
  logic [GHR_BITS-1:0]   w_ghr_next;
  logic                  w_unused;

  assign w_lookup_ready = (r_state == ST_RUN) && (r_pending < PEND_MAX);
  assign w_accept       = lookup_valid && w_lookup_ready;

  assign w_lk_idx     = lookup_pc[INDEX_BITS-1:0];
  assign w_lk_tag     = lookup_pc[INDEX_BITS +: TAG_BITS];
  assign w_lk_bht_idx = (GSHARE != 0) ? (w_lk_idx ^ INDEX_BITS'(r_ghr)) : w_lk_idx;

  // Reads use the pre-edge table contents, so a same-cycle update to the entry is not visible.
  assign w_hit     = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
  assign w_taken   = w_hit && r_bht[w_lk_bht_idx][CTR_BITS-1];
  assign w_pred_pc = w_taken ? r_btb_target[w_lk_idx] : (lookup_pc + PC_WIDTH'(1));

  assign w_upd        = update_valid && (r_state == ST_RUN);
  assign w_flush      = w_upd && update_mispredict;
  assign w_up_idx     = update_pc[INDEX_BITS-1:0];
  assign w_up_tag     = update_pc[INDEX_BITS +: TAG_BITS];
  assign w_up_bht_idx = (GSHARE != 0) ? (w_up_idx ^ INDEX_BITS'(update_ghr)) : w_up_idx;
  assign w_up_ctr     = r_bht[w_up_bht_idx];

  always_comb begin
    w_ctr_next = w_up_ctr;
    if (update_taken) begin
      if (w_up_ctr != CTR_MAX) w_ctr_next = w_up_ctr + CTR_BITS'(1);
    end else begin
      if (w_up_ctr != CTR_MIN) w_ctr_next = w_up_ctr - CTR_BITS'(1);
    end
  end

  assign w_inc = w_accept && w_hit;

  // A mispredict flushes everything younger, so it overrides the same-cycle increment and shift.
  always_comb begin
    w_pending_next = r_pending;
    if (w_flush) begin
      w_pending_next = '0;
    end else if (w_inc && !w_upd) begin
      w_pending_next = r_pending + PEND_W'(1);
    end else if (!w_inc && w_upd && (r_pending != '0)) begin
      w_pending_next = r_pending - PEND_W'(1);
    end
  end

  always_comb begin
    w_ghr_next = r_ghr;
    if (w_flush) begin
      w_ghr_next = GHR_BITS'({update_ghr, update_taken});
    end else if (w_inc) begin
      w_ghr_next = GHR_BITS'({r_ghr, w_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_sweep_idx  <= '0;
      r_ghr        <= '0;
      r_pending    <= '0;
      r_pred_valid <= 1'b0;
      r_pred_hit   <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_pc    <= '0;
      r_pred_ghr   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_pred_valid <= 1'b0;
          r_sweep_idx  <= r_sweep_idx + INDEX_BITS'(1);
          if (r_sweep_idx == IDX_LAST) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_pred_valid <= w_accept;
          if (w_accept) begin
            r_pred_hit   <= w_hit;
            r_pred_taken <= w_taken;
            r_pred_pc    <= w_pred_pc;
            r_pred_ghr   <= r_ghr;
          end
          r_ghr     <= w_ghr_next;
          r_pending <= w_pending_next;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Tables carry no reset; the INIT sweep clears them one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_btb_valid[r_sweep_idx] <= 1'b0;
        r_bht[r_sweep_idx]       <= CTR_WEAK_NT;
      end else if (w_upd) begin
        r_bht[w_up_bht_idx] <= w_ctr_next;
        if (update_taken) begin
          r_btb_valid[w_up_idx]  <= 1'b1;
          r_btb_tag[w_up_idx]    <= w_up_tag;
          r_btb_target[w_up_idx] <= update_target;
        end
      end
    end
  end

  assign lookup_ready  = w_lookup_ready;
  assign pred_valid    = r_pred_valid;
  assign pred_hit      = r_pred_hit;
  assign pred_taken    = r_pred_taken;
  assign pred_pc       = r_pred_pc;
  assign pred_ghr      = r_pred_ghr;
  assign pending_count = r_pending;
  assign o_dbg_state   = r_state;

  assign w_unused = ^{lookup_pc, update_pc, update_ghr};

endmodule
